// File: rtl/reg_file_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_pkg
// Shared defaults and types for the multi-port register file slice.
//   - *_DEF localparams : default values for the reg_file_mp parameters
//   - addr_width()      : register address width for a given register count
//   - reg_addr_t        : register index at the default register count
//   - reg_data_t        : register contents at the default data width
// ----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int NUM_RD_DEF   = 2;
    localparam int NUM_WR_DEF   = 1;
    localparam int BYPASS_DEF   = 1;

    // A two-entry file still needs one address bit, so clamp at 1.
    function automatic int addr_width(input int num_regs);
        return (num_regs <= 2) ? 1 : $clog2(num_regs);
    endfunction

    typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_addr_t;
    typedef logic [WIDTH_DEF-1:0]            reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_scoreboard
// One busy bit per architectural register, tracking producers that have been
// issued but have not yet written back.
//   clk         : clock, state updates on rising edge
//   rst         : synchronous active-high reset, clears every busy bit
//   issue_valid : a producer issued this cycle, targeting issue_rd
//   issue_rd    : destination register of the issued producer
//   wenable     : per-write-port enable (writeback)
//   rd          : flattened write-port addresses, port i at [i*ADDR_W +: ADDR_W]
//   busy        : busy vector, bit 0 is always 0
// ----------------------------------------------------------------------------
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int NUM_WR   = NUM_WR_DEF,
    localparam int ADDR_W   = addr_width(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_rd,
    input  logic [NUM_WR-1:0]        wenable,
    input  logic [NUM_WR*ADDR_W-1:0] rd,
    output logic [NUM_REGS-1:0]      busy
);

    logic [NUM_REGS-1:0] busy_next;

    // Clears from writeback are applied first and the issue set last, so a
    // register that is written back and re-issued in the same cycle stays
    // busy: the new producer is the one still in flight. Repeat issues simply
    // re-set the bit; there is no count of outstanding producers.
    always_comb begin
        busy_next = busy;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wenable[i] && (rd[i*ADDR_W +: ADDR_W] != '0)) begin
                busy_next[rd[i*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// ----------------------------------------------------------------------------
// reg_file_mp
// Parametrised multi-port integer register file with optional same-cycle
// write-to-read bypass and a per-register busy scoreboard. x0 reads as zero.
//   clk         : clock, all state updates on rising edge
//   rst         : synchronous active-high reset; also forces out/rs_busy to 0
//   wenable     : per-write-port enable
//   rd          : write addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_in       : write data, port i at [i*WIDTH +: WIDTH]
//   rs          : read addresses, port j at [j*ADDR_W +: ADDR_W]
//   out         : read data (combinational), port j at [j*WIDTH +: WIDTH]
//   issue_valid : producer issued this cycle, targets issue_rd
//   issue_rd    : destination of the issued producer
//   rs_busy     : per-read-port flag, operand still pending
// ----------------------------------------------------------------------------
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter  int WIDTH    = WIDTH_DEF,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int NUM_RD   = NUM_RD_DEF,
    parameter  int NUM_WR   = NUM_WR_DEF,
    parameter  int BYPASS   = BYPASS_DEF,
    localparam int ADDR_W   = addr_width(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wenable,
    input  logic [NUM_WR*ADDR_W-1:0] rd,
    input  logic [NUM_WR*WIDTH-1:0]  rd_in,
    input  logic [NUM_RD*ADDR_W-1:0] rs,
    output logic [NUM_RD*WIDTH-1:0]  out,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_rd,
    output logic [NUM_RD-1:0]        rs_busy
);

    // Parameter sanity checks, reported at elaboration.
    if ((NUM_REGS < 2) || ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : g_chk_regs
        $error("reg_file_mp: NUM_REGS must be a power of 2 and at least 2");
    end
    if (NUM_RD < 1) begin : g_chk_rd
        $error("reg_file_mp: NUM_RD must be at least 1");
    end
    if (NUM_WR < 1) begin : g_chk_wr
        $error("reg_file_mp: NUM_WR must be at least 1");
    end

    logic [WIDTH-1:0]    regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    // Unpacked views of the write ports; wr_hit excludes x0 so neither the
    // storage nor the bypass ever sees a write to it.
    logic [ADDR_W-1:0] wr_addr [NUM_WR];
    logic [WIDTH-1:0]  wr_data [NUM_WR];
    logic [NUM_WR-1:0] wr_hit;

    for (genvar i = 0; i < NUM_WR; i++) begin : g_wr
        assign wr_addr[i] = rd[i*ADDR_W +: ADDR_W];
        assign wr_data[i] = rd_in[i*WIDTH +: WIDTH];
        assign wr_hit[i]  = wenable[i] && (wr_addr[i] != '0);
    end

    // Ports are visited in ascending order, so on a write-write collision the
    // last (highest-index) non-blocking assignment takes effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_hit[i]) begin
                    regs[wr_addr[i]] <= wr_data[i];
                end
            end
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wenable     (wenable),
        .rd          (rd),
        .busy        (busy)
    );

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] raddr;
        logic [WIDTH-1:0]  rdata;
        logic              fwd;
        logic              rbusy;

        assign raddr = rs[j*ADDR_W +: ADDR_W];

        // With bypass enabled, a matching in-flight write supplies the data
        // (highest port wins) and also means the operand is no longer pending.
        // Without bypass the read sees the pre-edge contents and busy state.
        always_comb begin
            rdata = regs[raddr];
            fwd   = 1'b0;
            if (BYPASS != 0) begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (wr_hit[i] && (wr_addr[i] == raddr)) begin
                        rdata = wr_data[i];
                        fwd   = 1'b1;
                    end
                end
            end
            rbusy = busy[raddr] && !fwd;
            if (rst || (raddr == '0)) begin
                rdata = '0;
                rbusy = 1'b0;
            end
        end

        assign out[j*WIDTH +: WIDTH] = rdata;
        assign rs_busy[j]            = rbusy;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// ----------------------------------------------------------------------------
// tb_reg_file_mp
// Directed bench for reg_file_mp. Two instances share one stimulus stream:
// dut_nb (BYPASS=0) and dut_by (BYPASS=1), both with two read and two write
// ports. Each step queues the expected outputs of both instances, then pops
// and compares them against the combinational outputs before the next edge.
// ----------------------------------------------------------------------------
module tb_reg_file_mp;
    import reg_file_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  wenable;
    logic [9:0]  rd;
    logic [63:0] rd_in;
    logic [9:0]  rs;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [63:0] out_nb;
    logic [63:0] out_by;
    logic [1:0]  busy_nb;
    logic [1:0]  busy_by;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        string     tag;
        int        sel;
        reg_data_t exp;
    } exp_t;

    exp_t exp_q[$];

    reg_file_mp #(
        .WIDTH (32), .NUM_REGS (32), .NUM_RD (2), .NUM_WR (2), .BYPASS (0)
    ) dut_nb (
        .clk (clk), .rst (rst), .wenable (wenable), .rd (rd), .rd_in (rd_in),
        .rs (rs), .out (out_nb), .issue_valid (issue_valid),
        .issue_rd (issue_rd), .rs_busy (busy_nb)
    );

    reg_file_mp #(
        .WIDTH (32), .NUM_REGS (32), .NUM_RD (2), .NUM_WR (2), .BYPASS (1)
    ) dut_by (
        .clk (clk), .rst (rst), .wenable (wenable), .rd (rd), .rd_in (rd_in),
        .rs (rs), .out (out_by), .issue_valid (issue_valid),
        .issue_rd (issue_rd), .rs_busy (busy_by)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the sequence stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic reg_data_t observe(input int sel);
        case (sel)
            0:       return out_nb[31:0];
            1:       return out_nb[63:32];
            2:       return {31'b0, busy_nb[0]};
            3:       return {31'b0, busy_nb[1]};
            4:       return out_by[31:0];
            5:       return out_by[63:32];
            6:       return {31'b0, busy_by[0]};
            default: return {31'b0, busy_by[1]};
        endcase
    endfunction

    // Drive one cycle of inputs just after the falling edge.
    task automatic applyStimulus(input logic r, input logic [1:0] wen,
                                 input logic [4:0] a0, input reg_data_t d0,
                                 input logic [4:0] a1, input reg_data_t d1,
                                 input logic [4:0] s0, input logic [4:0] s1,
                                 input logic iv, input logic [4:0] ir);
        @(negedge clk);
        rst         = r;
        wenable     = wen;
        rd          = {a1, a0};
        rd_in       = {d1, d0};
        rs          = {s1, s0};
        issue_valid = iv;
        issue_rd    = ir;
    endtask

    // Queue expected outputs: no-bypass instance first, then bypass instance.
    task automatic expectStep(input string tag,
                              input reg_data_t n0, input reg_data_t n1, input logic [1:0] nb,
                              input reg_data_t b0, input reg_data_t b1, input logic [1:0] bb);
        exp_q.push_back('{ {tag, "/nb.out0"}, 0, n0 });
        exp_q.push_back('{ {tag, "/nb.out1"}, 1, n1 });
        exp_q.push_back('{ {tag, "/nb.busy0"}, 2, {31'b0, nb[0]} });
        exp_q.push_back('{ {tag, "/nb.busy1"}, 3, {31'b0, nb[1]} });
        exp_q.push_back('{ {tag, "/by.out0"}, 4, b0 });
        exp_q.push_back('{ {tag, "/by.out1"}, 5, b1 });
        exp_q.push_back('{ {tag, "/by.busy0"}, 6, {31'b0, bb[0]} });
        exp_q.push_back('{ {tag, "/by.busy1"}, 7, {31'b0, bb[1]} });
    endtask

    // Let the combinational outputs settle, then drain the scoreboard.
    task automatic checkOutput();
        exp_t      e;
        reg_data_t obs;
        #1;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.sel);
            assert_count++;
            assert (obs === e.exp) else begin
                fail_count++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; wenable = '0; rd = '0; rd_in = '0; rs = '0;
        issue_valid = 1'b0; issue_rd = '0;

        // Reset asserted: outputs forced to zero.
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 1, 2, 0, 0);
        expectStep("rst_hold", 0, 0, 2'b00, 0, 0, 2'b00); checkOutput();
        // After reset every register reads zero.
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 2, 0, 0);
        expectStep("post_rst", 0, 0, 2'b00, 0, 0, 2'b00); checkOutput();

        // Write x3=100: no-bypass sees old value, bypass sees new.
        applyStimulus(0, 2'b01, 3, 100, 0, 0, 3, 0, 0, 0);
        expectStep("wr_x3", 0, 0, 2'b00, 100, 0, 2'b00); checkOutput();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 3, 0, 0, 0);
        expectStep("rd_x3", 100, 0, 2'b00, 100, 0, 2'b00); checkOutput();

        // Write x5 on port 1 while reading x5 and x3.
        applyStimulus(0, 2'b10, 0, 0, 5, 32'hDEADBEEF, 5, 3, 0, 0);
        expectStep("wr_x5", 0, 100, 2'b00, 32'hDEADBEEF, 100, 2'b00); checkOutput();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 5, 3, 0, 0);
        expectStep("rd_x5", 32'hDEADBEEF, 100, 2'b00, 32'hDEADBEEF, 100, 2'b00); checkOutput();

        // Writes and issues to x0 are discarded and never forwarded.
        applyStimulus(0, 2'b11, 0, 200, 0, 300, 0, 0, 1, 0);
        expectStep("wr_x0", 0, 0, 2'b00, 0, 0, 2'b00); checkOutput();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        expectStep("rd_x0", 0, 0, 2'b00, 0, 0, 2'b00); checkOutput();

        // Both ports write x7: port 1 wins in storage and bypass.
        applyStimulus(0, 2'b11, 7, 11, 7, 22, 7, 7, 0, 0);
        expectStep("ww_x7", 0, 0, 2'b00, 22, 22, 2'b00); checkOutput();
        // Independent writes x8=1, x9=2 while reading x7 and x8.
        applyStimulus(0, 2'b11, 8, 1, 9, 2, 7, 8, 0, 0);
        expectStep("wr_x8x9", 22, 0, 2'b00, 22, 1, 2'b00); checkOutput();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 8, 9, 0, 0);
        expectStep("rd_x8x9", 1, 2, 2'b00, 1, 2, 2'b00); checkOutput();

        // Issue x4: not busy until after the edge.
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 4, 0, 1, 4);
        expectStep("iss_x4", 0, 0, 2'b00, 0, 0, 2'b00); checkOutput();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 4, 4, 0, 0);
        expectStep("busy_x4", 0, 0, 2'b11, 0, 0, 2'b11); checkOutput();
        // Writeback x4=55 on port 1: bypass clears busy the same cycle.
        applyStimulus(0, 2'b10, 0, 0, 4, 55, 4, 0, 0, 0);
        expectStep("wb_x4", 0, 0, 2'b01, 55, 0, 2'b00); checkOutput();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 4, 0, 0, 0);
        expectStep("done_x4", 55, 0, 2'b00, 55, 0, 2'b00); checkOutput();

        // Issue and write x4 together: set wins, value still updates.
        applyStimulus(0, 2'b01, 4, 66, 0, 0, 4, 0, 1, 4);
        expectStep("iss_wb_x4", 55, 0, 2'b00, 66, 0, 2'b00); checkOutput();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 4, 4, 0, 0);
        expectStep("set_wins", 66, 66, 2'b11, 66, 66, 2'b11); checkOutput();
        // Repeat issue to a busy register keeps it busy.
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 4, 4, 1, 4);
        expectStep("reiss_x4", 66, 66, 2'b11, 66, 66, 2'b11); checkOutput();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 4, 3, 0, 0);
        expectStep("still_busy", 66, 100, 2'b01, 66, 100, 2'b01); checkOutput();

        // Reset mid-operation: issue and write in the reset cycle are lost.
        applyStimulus(1, 2'b01, 11, 5, 0, 0, 4, 3, 1, 10);
        expectStep("rst_mid", 0, 0, 2'b00, 0, 0, 2'b00); checkOutput();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 4, 3, 0, 0);
        expectStep("after_rst", 0, 0, 2'b00, 0, 0, 2'b00); checkOutput();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 10, 11, 0, 0);
        expectStep("lost_ops", 0, 0, 2'b00, 0, 0, 2'b00); checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
